// File: rtl/clock_time_pkg.sv
// Shared types and constants for the time-of-day counter.
package clock_time_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    CHECK
  } state_t;

  localparam int unsigned LOAD_LIMIT  = 1_000_000;
  localparam logic [7:0]  HH_MAX      = 8'h23;
  localparam logic [7:0]  MS_MAX      = 8'h59;
  localparam int unsigned BIN_BITS    = 20;
  localparam int unsigned CONV_CYCLES = 20;

  // Two-digit BCD increment that wraps to 00 after max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) begin
      return 8'h00;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

endpackage

// File: rtl/bin20_to_bcd6.sv
// Sequential double-dabble: converts a 20-bit binary value to 6 BCD digits,
// one bit per cycle, started by i_start and finishing after CONV_CYCLES shifts.
module bin20_to_bcd6
  import clock_time_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [BIN_BITS-1:0] i_bin,
  output logic                o_done,
  output logic [23:0]         o_bcd
);

  localparam logic [4:0] LAST = 5'(CONV_CYCLES - 1);

  logic [BIN_BITS-1:0] bin_q;
  logic [23:0]         bcd_q;
  logic [23:0]         adj;
  logic [4:0]          cnt_q;
  logic                active_q;

  // Add-3 correction on every digit that is 5 or more before the shift.
  always_comb begin
    adj = '0;
    for (int unsigned d = 0; d < 6; d++) begin
      adj[4*d +: 4] = (bcd_q[4*d +: 4] >= 4'd5) ? bcd_q[4*d +: 4] + 4'd3 : bcd_q[4*d +: 4];
    end
  end

  // Shift register and iteration counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (i_start) begin
      bin_q    <= i_bin;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      bcd_q <= {adj[22:0], bin_q[BIN_BITS-1]};
      bin_q <= {bin_q[BIN_BITS-2:0], 1'b0};
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == LAST) begin
        active_q <= 1'b0;
      end
    end
  end

  // done marks the cycle whose closing edge performs the final shift.
  assign o_done = active_q && (cnt_q == LAST);
  assign o_bcd  = bcd_q;

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour HH:MM:SS time-of-day counter with a validated decimal load path.
// Optional build macro CLOCK_12H_EN adds o_pm and shows hours in 12-hour form.
module time_of_day_counter
  import clock_time_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned VALUE_W     = 40
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_run,
  output logic [7:0]         o_hh_bcd,
  output logic [7:0]         o_mm_bcd,
  output logic [7:0]         o_ss_bcd,
  output logic               o_busy,
  output logic               o_load_err,
  output logic               o_sec_pulse
`ifdef CLOCK_12H_EN
  ,
  output logic               o_pm
`endif
);

  localparam int unsigned        PRE_W   = $clog2(CLK_FREQ_HZ);
  localparam logic [PRE_W-1:0]   PRE_MAX = PRE_W'(CLK_FREQ_HZ - 1);
  localparam logic [VALUE_W-1:0] LIMIT   = VALUE_W'(LOAD_LIMIT);

  state_t           state_q, state_d;
  logic             range_q;
  logic             conv_start, conv_done;
  logic [23:0]      conv_bcd;
  logic             in_range, load_ok, tick, busy;
  logic [7:0]       hh_q, mm_q, ss_q;
  logic             err_q;
  logic [PRE_W-1:0] presc_q;

  bin20_to_bcd6 u_conv (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (conv_start),
    .i_bin   (i_value[BIN_BITS-1:0]),
    .o_done  (conv_done),
    .o_bcd   (conv_bcd)
  );

  assign in_range = (i_value < LIMIT);
  assign busy     = (state_q != IDLE);
  assign tick     = i_run && !busy && (presc_q == PRE_MAX);
  assign load_ok  = !range_q && (conv_bcd[23:16] <= HH_MAX) &&
                    (conv_bcd[15:8] <= MS_MAX) && (conv_bcd[7:0] <= MS_MAX);

  // Load FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Load FSM next state; out-of-range values skip conversion straight to CHECK.
  always_comb begin
    state_d    = state_q;
    conv_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_load) begin
          if (in_range) begin
            state_d    = CONV;
            conv_start = 1'b1;
          end else begin
            state_d = CHECK;
          end
        end
      end
      CONV:    if (conv_done) state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Range flag and sticky load error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      range_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && i_load) begin
        range_q <= !in_range;
      end
      if (state_q == CHECK) begin
        err_q <= !load_ok;
      end
    end
  end

  // Prescaler: frozen while busy so a load never eats part of a second.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q <= '0;
    end else if (state_q == CHECK && load_ok) begin
      presc_q <= '0;
    end else if (!i_run) begin
      presc_q <= '0;
    end else if (!busy) begin
      presc_q <= (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
    end
  end

  // Time registers: commit accepted load, otherwise advance with carries.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hh_q <= '0;
      mm_q <= '0;
      ss_q <= '0;
    end else if (state_q == CHECK && load_ok) begin
      hh_q <= conv_bcd[23:16];
      mm_q <= conv_bcd[15:8];
      ss_q <= conv_bcd[7:0];
    end else if (tick) begin
      ss_q <= bcd_inc(ss_q, MS_MAX);
      if (ss_q == MS_MAX) begin
        mm_q <= bcd_inc(mm_q, MS_MAX);
        if (mm_q == MS_MAX) begin
          hh_q <= bcd_inc(hh_q, HH_MAX);
        end
      end
    end
  end

  assign o_mm_bcd    = mm_q;
  assign o_ss_bcd    = ss_q;
  assign o_busy      = busy;
  assign o_load_err  = err_q;
  assign o_sec_pulse = tick;

`ifdef CLOCK_12H_EN
  // 12-hour display mapping; counting stays 24-hour internally.
  always_comb begin
    o_hh_bcd = hh_q;
    o_pm     = (hh_q >= 8'h12);
    case (hh_q)
      8'h00:   o_hh_bcd = 8'h12;
      8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19:
               o_hh_bcd = hh_q - 8'h12;
      8'h20:   o_hh_bcd = 8'h08;
      8'h21:   o_hh_bcd = 8'h09;
      8'h22:   o_hh_bcd = 8'h10;
      8'h23:   o_hh_bcd = 8'h11;
      default: o_hh_bcd = hh_q;
    endcase
  end
`else
  assign o_hh_bcd = hh_q;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Self-checking bench for time_of_day_counter (CLK_FREQ_HZ = 10).
module tb_time_of_day_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        run = 1'b0;
  logic [39:0] value = '0;
  logic [7:0]  o_hh, o_mm, o_ss;
  logic        o_busy, o_err, o_pulse;
`ifdef CLOCK_12H_EN
  logic        o_pm;
`endif

  time_of_day_counter #(
    .CLK_FREQ_HZ (10),
    .VALUE_W     (40)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_load      (load),
    .i_value     (value),
    .i_run       (run),
    .o_hh_bcd    (o_hh),
    .o_mm_bcd    (o_mm),
    .o_ss_bcd    (o_ss),
    .o_busy      (o_busy),
    .o_load_err  (o_err),
    .o_sec_pulse (o_pulse)
`ifdef CLOCK_12H_EN
    ,
    .o_pm        (o_pm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] value;
    logic [7:0]  hh;
    logic [7:0]  mm;
    logic [7:0]  ss;
    logic        err;
    int unsigned busy;
  } vec_t;

  vec_t        sb[$];
  vec_t        vecs[12];
  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected display hours for a 24-hour BCD value.
  function automatic logic [7:0] exp_hh(input logic [7:0] h);
`ifdef CLOCK_12H_EN
    int v;
    v = int'(h[7:4]) * 10 + int'(h[3:0]);
    if (v == 0) v = 12;
    else if (v > 12) v = v - 12;
    return {4'(v / 10), 4'(v % 10)};
`else
    return h;
`endif
  endfunction

  task automatic start_load(input logic [39:0] v);
    value = v;
    load  = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic wait_busy(output int unsigned n);
    n = 0;
    @(negedge clk);
    while (o_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input int unsigned n);
    vec_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_busy"}, n, e.busy);
      chk({tag, "_hh"}, 32'(o_hh), 32'(exp_hh(e.hh)));
      chk({tag, "_mm"}, 32'(o_mm), 32'(e.mm));
      chk({tag, "_ss"}, 32'(o_ss), 32'(e.ss));
      chk({tag, "_err"}, 32'(o_err), 32'(e.err));
`ifdef CLOCK_12H_EN
      chk({tag, "_pm"}, 32'(o_pm), 32'(e.hh >= 8'h12));
`endif
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned n;
    sb.push_back(v);
    start_load(v.value);
    wait_busy(n);
    check_result(tag, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned np;
    int unsigned n;

    vecs[0]  = '{40'd123456,      8'h12, 8'h34, 8'h56, 1'b0, 21};
    vecs[1]  = '{40'd126000,      8'h12, 8'h34, 8'h56, 1'b1, 21};
    vecs[2]  = '{40'd1000000,     8'h12, 8'h34, 8'h56, 1'b1, 1};
    vecs[3]  = '{40'd100,         8'h00, 8'h01, 8'h00, 1'b0, 21};
    vecs[4]  = '{40'd240000,      8'h00, 8'h01, 8'h00, 1'b1, 21};
    vecs[5]  = '{40'd6000,        8'h00, 8'h01, 8'h00, 1'b1, 21};
    vecs[6]  = '{40'd999999,      8'h00, 8'h01, 8'h00, 1'b1, 21};
    vecs[7]  = '{40'hFF_FFFF_FFFF, 8'h00, 8'h01, 8'h00, 1'b1, 1};
    vecs[8]  = '{40'd235959,      8'h23, 8'h59, 8'h59, 1'b0, 21};
    vecs[9]  = '{40'd0,           8'h00, 8'h00, 8'h00, 1'b0, 21};
    vecs[10] = '{40'd95907,       8'h09, 8'h59, 8'h07, 1'b0, 21};
    vecs[11] = '{40'd123456,      8'h12, 8'h34, 8'h56, 1'b0, 21};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_hh", 32'(o_hh), 32'(exp_hh(8'h00)));
    chk("rst_mm", 32'(o_mm), 32'h0);
    chk("rst_ss", 32'(o_ss), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_err", 32'(o_err), 32'h0);
    chk("rst_pulse", 32'(o_pulse), 32'h0);

    // Free run 25 cycles: two seconds, two pulses
    rst_n = 1'b1;
    run   = 1'b1;
    np    = 0;
    repeat (25) begin
      if (o_pulse) np++;
      @(negedge clk);
    end
    chk("run25_ss", 32'(o_ss), 32'h02);
    chk("run25_mm", 32'(o_mm), 32'h00);
    chk("run25_pulses", np, 32'd2);
    run = 1'b0;
    @(negedge clk);

    // Table of loads with time frozen
    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Frozen for 50 cycles
    np = 0;
    repeat (50) begin
      if (o_pulse) np++;
      @(negedge clk);
    end
    chk("hold_ss", 32'(o_ss), 32'h56);
    chk("hold_mm", 32'(o_mm), 32'h34);
    chk("hold_pulses", np, 32'd0);

    // Rollover 23:59:58 -> 23:59:59 -> 00:00:00
    run_vec('{40'd235958, 8'h23, 8'h59, 8'h58, 1'b0, 21}, "roll_load");
    run = 1'b1;
    repeat (10) @(negedge clk);
    chk("roll1_hh", 32'(o_hh), 32'(exp_hh(8'h23)));
    chk("roll1_ss", 32'(o_ss), 32'h59);
    repeat (10) @(negedge clk);
    chk("roll2_hh", 32'(o_hh), 32'(exp_hh(8'h00)));
    chk("roll2_mm", 32'(o_mm), 32'h00);
    chk("roll2_ss", 32'(o_ss), 32'h00);

    // Prescaler frozen during a rejected load: partial count preserved
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    repeat (5) @(negedge clk);
    run_vec('{40'd126000, 8'h00, 8'h00, 8'h00, 1'b1, 21}, "frz");
    repeat (3) @(negedge clk);
    chk("frz_ss_before", 32'(o_ss), 32'h00);
    chk("frz_pulse", 32'(o_pulse), 32'h1);
    @(negedge clk);
    chk("frz_ss_after", 32'(o_ss), 32'h01);
    run = 1'b0;
    @(negedge clk);

    // Second load during busy is dropped
    sb.push_back('{40'd0, 8'h00, 8'h00, 8'h00, 1'b0, 21});
    start_load(40'd0);
    n = 0;
    @(negedge clk);
    while (o_busy && n < 100) begin
      n++;
      if (n == 5) begin
        value = 40'd111111;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check_result("dbl", n);
    repeat (2) @(negedge clk);
    chk("dbl_no_requeue", 32'(o_busy), 32'h0);
    chk("dbl_ss", 32'(o_ss), 32'h00);

    // Reset in the middle of a conversion
    run_vec('{40'd10203, 8'h01, 8'h02, 8'h03, 1'b0, 21}, "pre_rst");
    run_vec('{40'd240000, 8'h01, 8'h02, 8'h03, 1'b1, 21}, "pre_rst_err");
    start_load(40'd123456);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hh", 32'(o_hh), 32'(exp_hh(8'h00)));
    chk("mid_rst_mm", 32'(o_mm), 32'h00);
    chk("mid_rst_ss", 32'(o_ss), 32'h00);
    chk("mid_rst_busy", 32'(o_busy), 32'h0);
    chk("mid_rst_err", 32'(o_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("post_rst_busy", 32'(o_busy), 32'h0);
    chk("post_rst_ss", 32'(o_ss), 32'h00);

`ifdef CLOCK_12H_EN
    run_vec('{40'd130000, 8'h13, 8'h00, 8'h00, 1'b0, 21}, "h12_pm");
    chk("h12_pm_hh", 32'(o_hh), 32'h01);
    chk("h12_pm_flag", 32'(o_pm), 32'h1);
    run_vec('{40'd120000, 8'h12, 8'h00, 8'h00, 1'b0, 21}, "h12_noon");
    run_vec('{40'd0, 8'h00, 8'h00, 8'h00, 1'b0, 21}, "h12_midnight");
    chk("h12_midnight_hh", 32'(o_hh), 32'h12);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
